// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises MIPS imem/dmem requests onto one single-ported RAM, with a watchdog.
// Define MEM_ARBITER_RR_EN for round-robin arbitration; otherwise data has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              halt,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ack,
  output logic              bus_err
);

  localparam int              WD_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT);
  localparam bit              WD_EN  = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_IACC = 2'd1,
    S_DACC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WD_W-1:0]   r_wdog;
  logic              r_dwr;
  logic              r_ihit;
  logic              r_dhit;
  logic [DATA_W-1:0] r_iload;
  logic [DATA_W-1:0] r_dload;
  logic              r_ramren;
  logic              r_ramwen;
  logic [ADDR_W-1:0] r_ramaddr;
  logic [DATA_W-1:0] r_ramstore;
  logic              r_buserr;

  logic w_dreq;
  logic w_ireq;
  logic w_grant_d;
  logic w_grant_i;
  logic w_in_acc;
  logic w_expire;

`ifdef MEM_ARBITER_RR_EN
  logic r_last_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_last_d <= 1'b0;
    end else if (w_grant_d) begin
      r_last_d <= 1'b1;
    end else if (w_grant_i) begin
      r_last_d <= 1'b0;
    end else begin
      r_last_d <= r_last_d;
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_d) begin
          w_next = S_DACC;
        end else if (w_grant_i) begin
          w_next = S_IACC;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_IACC, S_DACC: begin
        if (ram_ack || w_expire) begin
          w_next = S_DONE;
        end else begin
          w_next = r_state;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Grant decision and watchdog expiry; the abort fires on the edge where the count reaches TIMEOUT.
  always_comb begin
    w_dreq    = dREN | dWEN;
    w_ireq    = iREN & ~halt;
    w_grant_d = 1'b0;
    w_grant_i = 1'b0;
    w_in_acc  = (r_state == S_IACC) || (r_state == S_DACC);
    w_expire  = 1'b0;
    if (r_state == S_IDLE) begin
`ifdef MEM_ARBITER_RR_EN
      if (w_dreq && w_ireq) begin
        w_grant_d = ~r_last_d;
        w_grant_i = r_last_d;
      end else begin
        w_grant_d = w_dreq;
        w_grant_i = w_ireq;
      end
`else
      w_grant_d = w_dreq;
      w_grant_i = w_ireq & ~w_dreq;
`endif
    end else begin
      w_grant_d = 1'b0;
      w_grant_i = 1'b0;
    end
    if (WD_EN && w_in_acc && !ram_ack) begin
      w_expire = (r_wdog == (WD_LIM - WD_W'(1)));
    end else begin
      w_expire = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wdog     <= '0;
      r_dwr      <= 1'b0;
      r_ihit     <= 1'b0;
      r_dhit     <= 1'b0;
      r_iload    <= '0;
      r_dload    <= '0;
      r_ramren   <= 1'b0;
      r_ramwen   <= 1'b0;
      r_ramaddr  <= '0;
      r_ramstore <= '0;
      r_buserr   <= 1'b0;
    end else begin
      r_ihit <= 1'b0;
      r_dhit <= 1'b0;
      if (w_grant_d) begin
        r_ramaddr  <= daddr;
        r_ramstore <= dstore;
        r_ramwen   <= dWEN;
        r_ramren   <= ~dWEN;
        r_dwr      <= dWEN;
        r_wdog     <= '0;
      end else if (w_grant_i) begin
        r_ramaddr  <= iaddr;
        r_ramstore <= '0;
        r_ramren   <= 1'b1;
        r_ramwen   <= 1'b0;
        r_wdog     <= '0;
      end else if (w_in_acc && ram_ack) begin
        r_ramren <= 1'b0;
        r_ramwen <= 1'b0;
        // Hit only if the requester is still asking; the RAM side completes regardless.
        if (r_state == S_IACC) begin
          r_iload <= ramload;
          r_ihit  <= iREN;
        end else begin
          if (!r_dwr) begin
            r_dload <= ramload;
          end
          r_dhit <= r_dwr ? dWEN : dREN;
        end
      end else if (w_expire) begin
        r_ramren <= 1'b0;
        r_ramwen <= 1'b0;
        r_buserr <= 1'b1;
        r_wdog   <= WD_LIM;
      end else if (w_in_acc && (r_wdog != WD_LIM)) begin
        r_wdog <= r_wdog + WD_W'(1);
      end
    end
  end

  assign ihit     = r_ihit;
  assign dhit     = r_dhit;
  assign iload    = r_iload;
  assign dload    = r_dload;
  assign ramREN   = r_ramren;
  assign ramWEN   = r_ramwen;
  assign ramaddr  = r_ramaddr;
  assign ramstore = r_ramstore;
  assign bus_err  = r_buserr;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter checked every cycle against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          CLK = 1'b0;
  logic          RST, halt, iREN, dREN, dWEN, ram_ack;
  logic [AW-1:0] iaddr, daddr;
  logic [DW-1:0] dstore, ramload;
  logic          ihit, dhit, ramREN, ramWEN, bus_err;
  logic [DW-1:0] iload, dload, ramstore;
  logic [AW-1:0] ramaddr;

  int n_chk  = 0;
  int n_pass = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .halt(halt),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ack(ram_ack), .bus_err(bus_err)
  );

  always #5 CLK = ~CLK;

  // Reference model: who owns the RAM (0 none, 1 instr, 2 data), a one-cycle cool-down, wait count.
  int          m_owner, m_cool, m_wait;
  bit          m_wr, m_last_d;
  logic        e_ihit, e_dhit, e_ren, e_wen, e_err;
  logic [31:0] e_iload, e_dload, e_addr, e_store;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_step();
    bit dq, iq, pick_d, pick_i;
    if (RST) begin
      m_owner = 0; m_cool = 0; m_wait = 0; m_wr = 0; m_last_d = 0;
      e_ihit = 0; e_dhit = 0; e_ren = 0; e_wen = 0; e_err = 0;
      e_iload = 0; e_dload = 0; e_addr = 0; e_store = 0;
      return;
    end
    e_ihit = 0;
    e_dhit = 0;
    if (m_cool != 0) begin
      m_cool = 0;
    end else if (m_owner == 0) begin
      dq = dREN | dWEN;
      iq = iREN & ~halt;
      pick_d = dq;
      pick_i = iq & ~dq;
`ifdef MEM_ARBITER_RR_EN
      if (dq && iq) begin
        pick_d = !m_last_d;
        pick_i = m_last_d;
      end
`endif
      if (pick_d) begin
        m_owner = 2; m_wr = dWEN; m_wait = 0; m_last_d = 1;
        e_addr = daddr; e_store = dstore; e_wen = dWEN; e_ren = !dWEN;
      end else if (pick_i) begin
        m_owner = 1; m_wait = 0; m_last_d = 0;
        e_addr = iaddr; e_store = 0; e_ren = 1; e_wen = 0;
      end
    end else if (ram_ack) begin
      e_ren = 0; e_wen = 0;
      if (m_owner == 1) begin
        e_iload = ramload;
        e_ihit  = iREN;
      end else begin
        if (!m_wr) e_dload = ramload;
        e_dhit = m_wr ? dWEN : dREN;
      end
      m_owner = 0; m_cool = 1;
    end else if (m_wait + 1 >= TO) begin
      e_ren = 0; e_wen = 0; e_err = 1;
      m_owner = 0; m_cool = 1;
    end else begin
      m_wait++;
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge CLK);
    #1;
    check_eq("ram_bus", {ramREN, ramWEN, ramaddr, ramstore}, {e_ren, e_wen, e_addr, e_store});
    check_eq("hit_err", {ihit, dhit, bus_err}, {e_ihit, e_dhit, e_err});
    check_eq("iload", iload, e_iload);
    check_eq("dload", dload, e_dload);
    if (e_ihit) iREN = 1'b0;
    if (e_dhit) begin dREN = 1'b0; dWEN = 1'b0; end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  initial begin
    int unsigned r;
    RST = 1; halt = 0; iREN = 0; dREN = 0; dWEN = 0; ram_ack = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
    run(2);
    RST = 0;
    // read latency with ram_ack tied high
    iREN = 1; iaddr = 32'h0000_0040; ram_ack = 1; ramload = 32'h2402_0005;
    run(4);
    // write and instruction requested together
    iREN = 1; iaddr = 32'h0000_0044; dWEN = 1; daddr = 32'h0000_0100;
    dstore = 32'hDEAD_BEEF; ram_ack = 0;
    run(3);
    ram_ack = 1;
    run(6);
    // data read dropped mid-access
    dREN = 1; daddr = 32'h0000_0200; ram_ack = 0; ramload = 32'h1234_5678;
    run(2);
    dREN = 0;
    run(1);
    ram_ack = 1;
    run(3);
    // watchdog expiry then a normal access
    dREN = 1; daddr = 32'h0000_0300; ram_ack = 0; ramload = 32'hCAFE_0001;
    run(7);
    ram_ack = 1;
    run(4);
    // halt blocks instruction grants only
    halt = 1; iREN = 1; iaddr = 32'h0000_0080; dREN = 1; daddr = 32'h0000_0400;
    ramload = 32'h0BAD_F00D;
    run(8);
    halt = 0;
    run(4);
    // reset during an instruction access
    iREN = 1; iaddr = 32'h0000_0090; ram_ack = 0;
    run(2);
    RST = 1;
    run(1);
    RST = 0; iREN = 0;
    run(3);
    // randomised traffic
    for (int c = 0; c < 3000; c++) begin
      if (!iREN && $urandom_range(0, 3) == 0) begin
        iREN = 1; iaddr = $urandom;
      end else if (iREN && $urandom_range(0, 40) == 0) begin
        iREN = 0;
      end
      if (!dREN && !dWEN && $urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, 2);
        dREN = (r != 1); dWEN = (r != 0); daddr = $urandom; dstore = $urandom;
      end else if ((dREN || dWEN) && $urandom_range(0, 40) == 0) begin
        dREN = 0; dWEN = 0;
      end
      halt    = ($urandom_range(0, 7) == 0);
      ram_ack = ($urandom_range(0, 9) < 6);
      ramload = $urandom;
      RST     = ($urandom_range(0, 299) == 0);
      cyc();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
